// File: rtl/flipflop_circuit.sv
// rtl/flipflop_circuit.sv - T flip-flop plus alternation detector on a serial control bit
module flipflop_circuit #(
  parameter int ALT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y,
  output logic q
);

  // Run counter must be able to hold ALT_LEN itself, since it saturates there.
  localparam int RUN_W = $clog2(ALT_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALT_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             toggle_q, toggle_d;
  logic             prev_x_q, prev_x_d;
  logic             valid_q, valid_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             y_q, y_d;

  // Next-state logic: toggle on x, track alternation length, flag when run reaches ALT_LEN.
  always_comb begin
    toggle_d = toggle_q ^ x;
    prev_x_d = x;
    valid_d  = 1'b1;
    run_d    = RUN_ONE;
    if (valid_q && (x != prev_x_q)) begin
      // Saturate so a long alternating stream keeps y high instead of wrapping.
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
    end
    y_d = (run_d == RUN_MAX);
  end

  // State register; reset clears everything immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      prev_x_q <= 1'b0;
      valid_q  <= 1'b0;
      run_q    <= '0;
      y_q      <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      prev_x_q <= prev_x_d;
      valid_q  <= valid_d;
      run_q    <= run_d;
      y_q      <= y_d;
    end
  end

  assign q = toggle_q;
  assign y = y_q;

endmodule

// File: tb/tb_flipflop_circuit.sv
// tb/tb_flipflop_circuit.sv - directed bench for flipflop_circuit at ALT_LEN 4, 2 and 8
module tb_flipflop_circuit;

  logic clk;
  logic reset;
  logic x;
  logic y4, q4, y2, q2, y8, q8;
  logic exp_q;
  int   total;
  int   bad;

  flipflop_circuit #(.ALT_LEN(4)) dut4 (.clk(clk), .reset(reset), .x(x), .y(y4), .q(q4));
  flipflop_circuit #(.ALT_LEN(2)) dut2 (.clk(clk), .reset(reset), .x(x), .y(y2), .q(q2));
  flipflop_circuit #(.ALT_LEN(8)) dut8 (.clk(clk), .reset(reset), .x(x), .y(y8), .q(q8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive x on the falling edge, check the ALT_LEN=4 outputs just after the rising edge.
  task automatic step(input string tag, input logic v, input logic ey);
    @(negedge clk);
    x = v;
    @(posedge clk);
    #1;
    exp_q = exp_q ^ v;
    chk({tag, ".q"}, {7'd0, q4}, {7'd0, exp_q});
    chk({tag, ".y"}, {7'd0, y4}, {7'd0, ey});
  endtask

  // Short reset pulse entirely between two rising edges; called right after a step.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    exp_q = 1'b0;
    chk({tag, ".q4"}, {7'd0, q4}, 8'd0);
    chk({tag, ".y4"}, {7'd0, y4}, 8'd0);
    chk({tag, ".y2"}, {7'd0, y2}, 8'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_q = 1'b0;
    x     = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", {7'd0, q4}, 8'd0);
    chk("rst.y", {7'd0, y4}, 8'd0);
    chk("rst.y8", {7'd0, y8}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: x held low keeps everything low; then reset clears a set q asynchronously
    for (int i = 0; i < 5; i++) step("t1.zero", 1'b0, 1'b0);
    step("t1.one", 1'b1, 1'b0);
    chk("t1.q_set", {7'd0, q4}, 8'd1);
    pulse_reset("t1.async");

    // 2: repeated ones toggle q but never alternate
    step("t2.a", 1'b1, 1'b0);
    step("t2.b", 1'b1, 1'b0);
    step("t2.c", 1'b1, 1'b0);
    chk("t2.q_end", {7'd0, q4}, 8'd1);
    pulse_reset("t2.rst");

    // 3: 0,1,0,1 raises y on the 4th sample, stays high while alternation continues
    step("t3.s1", 1'b0, 1'b0);
    chk("t3.y2_s1", {7'd0, y2}, 8'd0);
    step("t3.s2", 1'b1, 1'b0);
    chk("t3.y2_s2", {7'd0, y2}, 8'd1);
    step("t3.s3", 1'b0, 1'b0);
    step("t3.s4", 1'b1, 1'b1);
    chk("t3.q_s4", {7'd0, q4}, 8'd0);
    step("t3.s5", 1'b0, 1'b1);
    step("t3.s6", 1'b1, 1'b1);

    // 4: repeated 1 drops y; three more alternating samples restore it
    step("t4.rep", 1'b1, 1'b0);
    step("t4.a1", 1'b0, 1'b0);
    step("t4.a2", 1'b1, 1'b0);
    step("t4.a3", 1'b0, 1'b1);
    pulse_reset("t4.rst");

    // 5: reset mid-run restarts tracking, so the next 1 is a first sample
    step("t5.s1", 1'b0, 1'b0);
    step("t5.s2", 1'b1, 1'b0);
    step("t5.s3", 1'b0, 1'b0);
    pulse_reset("t5.mid");
    step("t5.after", 1'b1, 1'b0);
    chk("t5.q", {7'd0, q4}, 8'd1);
    pulse_reset("t5.rst");

    // 6: ALT_LEN=8 rises exactly on the 8th alternating sample
    for (int i = 1; i <= 8; i++) begin
      step("t6.alt", (i % 2) == 1, i >= 4);
      chk($sformatf("t6.y8_s%0d", i), {7'd0, y8}, {7'd0, i == 8});
    end
    step("t6.rep", 1'b0, 1'b0);
    chk("t6.y8_rep", {7'd0, y8}, 8'd0);
    chk("t6.y2_rep", {7'd0, y2}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flipflop_circuit.md
Name: flipflop_circuit

Overview:
- Small sequential block built around a single input bit `x` sampled on every rising clock edge.
- Provides a T-flip-flop state bit `q`, which toggles whenever `x` is sampled high.
- Provides a registered alternation-detect flag `y`, asserted once `x` has alternated (0/1/0/1… or 1/0/1/0…) across `ALT_LEN` consecutive samples.
- Used as a toggle/activity monitor on a serial control line.

Parameters:
- `ALT_LEN`, default 4: number of consecutive alternating samples needed to assert `y`. Legal range 2..255.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `x`  input  1  serial data/control bit, sampled on the rising edge of `clk`.
- `y`  output  1  registered alternation-detect flag.
- `q`  output  1  registered T-flip-flop state.

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on the rising edge of `clk`.
  - Reset is asynchronous and active-high. While `reset`=1, all state is held at reset values regardless of `clk`.
  - Reset values: `q`=0, `y`=0, internal `prev_x`=0, `valid`=0, `run`=0.
  - Before the first reset assertion, outputs are unspecified (X allowed). No power-on initialisation is required.
  - The rising edge coincident with reset deassertion is not sampled. First functional edge is the first rising edge strictly after `reset` falls.
- `q` (T flip-flop):
  - On each functional edge: if `x`=1 then `q` <= ~`q`; else `q` holds.
  - `q` is driven directly from the flop; no combinational path from `x`.
- Alternation tracker:
  - Internal state: `prev_x` (1 bit), `valid` (1 bit), `run` (`$clog2(ALT_LEN+1)` bits, unsigned).
  - First functional edge after reset (`valid`=0): `prev_x` <= `x`, `valid` <= 1, `run` <= 1.
  - Later edges (`valid`=1):
    - `x` != `prev_x` -> `run` <= min(`run`+1, `ALT_LEN`), i.e. saturating at `ALT_LEN`.
    - `x` == `prev_x` -> `run` <= 1.
    - `prev_x` <= `x` always.
- `y` (Moore, registered):
  - `y` <= (next value of `run` == `ALT_LEN`).
  - `y` goes high on the same edge that samples the `ALT_LEN`-th alternating bit: latency 0 cycles after that sample, visible after the edge.
  - `y` stays high while alternation continues; counter saturation guarantees no wrap.
  - `y` falls on the first edge that samples a repeated value.
- Reset mid-operation:
  - `q`, `y` and `run` clear immediately, asynchronously, without waiting for a clock edge.
  - Tracking restarts from the `valid`=0 condition after reset deasserts.
- Output timing:
  - No outputs are combinational from `x`.
  - `y` and `q` change only on clock edges or on reset assertion.

Test Plan:
1. Reset pulse with `x`=0, then hold `x`=0 for 5 edges -> `q`=0, `y`=0 throughout. Assert `reset` between edges -> `q` and `y` go to 0 immediately.
2. After reset, drive `x`=1,1,1 on 3 edges -> `q` goes 1,0,1 after each edge; `y` stays 0 (`run` stays 1).
3. After reset, drive `x`=0,1,0,1 on edges 1-4 (`ALT_LEN`=4):
   - `q` sequence 0,1,1,0.
   - `y` 0,0,0,1, rising after edge 4.
   - Continue `x`=0,1 -> `y` stays 1 (saturation).
4. From state `y`=1, drive a repeated value (`x`=1 following 1) -> `y`=0 after that edge; `run` restarts at 1. Needs 3 more alternating samples to re-assert `y`.
5. Mid-run reset: after `x`=0,1,0 (`run`=3), assert `reset` for less than one clock period, then drive `x`=1 -> `y` stays 0 (`run`=1, not 4); `q`=1.
6. Parameter sweep with `ALT_LEN`=2 -> `y` asserts on the second sample of the pattern 0,1. With `ALT_LEN`=8, alternating input -> `y` rises exactly on the 8th sample.
